// File: rtl/leaf_pkt_pkg.sv
// Shared BFT packet field layout, control opcodes and credit limits for the leaf interface.
package leaf_pkt_pkg;

  localparam int unsigned PAYLOAD_W = 32;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned PORT_W    = 4;
  localparam int unsigned LEAF_W    = 5;
  localparam int unsigned PKT_W     = 1 + LEAF_W + PORT_W + ADDR_W + PAYLOAD_W;

  localparam int unsigned ADDR_LSB  = PAYLOAD_W;
  localparam int unsigned PORT_LSB  = ADDR_LSB + ADDR_W;
  localparam int unsigned LEAF_LSB  = PORT_LSB + PORT_W;
  localparam int unsigned VALID_BIT = LEAF_LSB + LEAF_W;

  localparam int unsigned CREDIT_W   = ADDR_W + 1;
  localparam int unsigned MAX_CREDIT = 1 << ADDR_W;

  localparam logic [PORT_W-1:0] CTRL_PORT = '0;

  typedef enum logic [3:0] {
    OP_BIND   = 4'd0,
    OP_CREDIT = 4'd1
  } ctrl_op_e;

  typedef struct packed {
    logic                 valid;
    logic [LEAF_W-1:0]    leaf;
    logic [PORT_W-1:0]    port;
    logic [ADDR_W-1:0]    addr;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

endpackage

// File: rtl/leaf_packet_tx_if.sv
// User-operator output streams (ap_vld/ap_ack) feeding the leaf transmit path.
interface leaf_packet_tx_if #(
  parameter int unsigned NUM_OUT_PORTS = 2,
  parameter int unsigned PAYLOAD_BITS  = 32
) ();
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user
  );
endinterface

// File: rtl/leaf_tx_arbiter.sv
// One-hot grant among eligible output ports; LEAF_TX_RR_EN selects round-robin,
// otherwise fixed priority with the lowest index winning.
module leaf_tx_arbiter #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic                 enable,
  output logic [NUM_PORTS-1:0] grant
);
`ifdef LEAF_TX_RR_EN
  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;

  // Search starts at the pointer and wraps, so the last winner becomes lowest priority.
  always_comb begin
    int unsigned idx;
    grant   = '0;
    found   = 1'b0;
    ptr_nxt = ptr;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && enable && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = (idx == NUM_PORTS - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr <= '0;
    else if (found) ptr <= ptr_nxt;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found && enable && eligible[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/leaf_packet_tx.sv
// Leaf transmit path: packs accepted user words into BFT packets with per-port binding and credit.
// Arbitration policy set by LEAF_TX_RR_EN (round-robin) in leaf_tx_arbiter; default is fixed priority.
module leaf_packet_tx
  import leaf_pkt_pkg::*;
#(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned NUM_OUT_PORTS         = 2,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                   clk_bft,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0] dout_leaf_interface2bft,
  input  logic                   resend,
  leaf_packet_tx_if.slave        user
);
  pkt_t in_pkt;
  assign in_pkt = din_leaf_bft2interface;

  logic       ctrl_vld;
  logic [3:0] ctrl_op;
  logic [3:0] ctrl_idx;
  assign ctrl_vld = in_pkt.valid && (in_pkt.port == CTRL_PORT);
  assign ctrl_op  = in_pkt.payload[31:28];
  assign ctrl_idx = in_pkt.payload[27:24];

  logic unused_in;
  assign unused_in = ^{in_pkt.leaf, in_pkt.addr, in_pkt.payload[23:15], in_pkt.payload[5:0]};

  logic [NUM_OUT_PORTS-1:0] bound;
  logic [LEAF_W-1:0]        dest_leaf  [NUM_OUT_PORTS];
  logic [PORT_W-1:0]        dest_port  [NUM_OUT_PORTS];
  logic [ADDR_W-1:0]        addr       [NUM_OUT_PORTS];
  logic [CREDIT_W-1:0]      credit     [NUM_OUT_PORTS];
  logic [CREDIT_W-1:0]      credit_nxt [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] bind_hit;
  logic [NUM_OUT_PORTS-1:0] credit_hit;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     can_grant;

  always_comb begin
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i]   = user.vld_user2interface[i] & bound[i] & (credit[i] != '0);
      bind_hit[i]   = ctrl_vld && (ctrl_op == OP_BIND)   && (ctrl_idx == 4'(i));
      credit_hit[i] = ctrl_vld && (ctrl_op == OP_CREDIT) && (ctrl_idx == 4'(i));
    end
  end

  // A held packet may only be replaced once the link is not stalling.
  assign can_grant = reset & (~resend | ~dout_leaf_interface2bft[VALID_BIT]);

  leaf_tx_arbiter #(
    .NUM_PORTS(NUM_OUT_PORTS)
  ) u_arb (
    .clk      (clk_bft),
    .reset    (reset),
    .eligible (eligible),
    .enable   (can_grant),
    .grant    (grant)
  );

  assign user.ack_interface2user = grant;

  logic [LEAF_W-1:0]       sel_leaf;
  logic [PORT_W-1:0]       sel_port;
  logic [ADDR_W-1:0]       sel_addr;
  logic [PAYLOAD_BITS-1:0] sel_word;

  always_comb begin
    sel_leaf = '0;
    sel_port = '0;
    sel_addr = '0;
    sel_word = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        sel_leaf = dest_leaf[i];
        sel_port = dest_port[i];
        sel_addr = addr[i];
        sel_word = user.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // Send and returned credit on the same cycle combine before saturating.
  always_comb begin
    logic [CREDIT_W:0] sum;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, credit[i]} - {{CREDIT_W{1'b0}}, grant[i]};
      if (credit_hit[i]) sum = sum + (CREDIT_W+1)'(FREESPACE_UPDATE_SIZE);
      if (sum > (CREDIT_W+1)'(MAX_CREDIT)) sum = (CREDIT_W+1)'(MAX_CREDIT);
      credit_nxt[i] = sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk_bft) begin
    if (!reset) begin
      dout_leaf_interface2bft <= '0;
      bound                   <= '0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_leaf[i] <= '0;
        dest_port[i] <= '0;
        addr[i]      <= '0;
        credit[i]    <= CREDIT_W'(MAX_CREDIT);
      end
    end else begin
      if (can_grant) begin
        if (|grant) dout_leaf_interface2bft <= {1'b1, sel_leaf, sel_port, sel_addr, sel_word};
        else        dout_leaf_interface2bft <= '0;
      end
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (bind_hit[i]) begin
          bound[i]     <= 1'b1;
          dest_leaf[i] <= in_pkt.payload[14:10];
          dest_port[i] <= in_pkt.payload[9:6];
          addr[i]      <= '0;
        end else if (grant[i]) begin
          addr[i] <= addr[i] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_leaf_packet_tx.sv
// Self-checking bench for leaf_packet_tx against a queue/array-level model of the link rules.
module tb_leaf_packet_tx;
  localparam int N = 2;

  logic        clk_bft = 1'b0;
  logic        reset;
  logic        resend;
  logic [48:0] din_bft;
  logic [48:0] dout;

  leaf_packet_tx_if #(.NUM_OUT_PORTS(N), .PAYLOAD_BITS(32)) u_if ();

  leaf_packet_tx #(
    .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5), .NUM_PORT_BITS(4),
    .NUM_ADDR_BITS(7), .NUM_OUT_PORTS(N), .FREESPACE_UPDATE_SIZE(64)
  ) dut (
    .clk_bft                 (clk_bft),
    .reset                   (reset),
    .din_leaf_bft2interface  (din_bft),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend),
    .user                    (u_if.slave)
  );

  always #5 clk_bft = ~clk_bft;

  int          m_bound  [N];
  int          m_leaf   [N];
  int          m_port   [N];
  int          m_addr   [N];
  int          m_credit [N];
  int          m_rr;
  logic [48:0] m_dout;
  int          ack_count [N];
  logic [N-1:0] last_ack, prev_ack;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
`ifdef LEAF_TX_RR_EN
      int i = (m_rr + k) % N;
`else
      int i = k;
`endif
      if (u_if.vld_user2interface[i] && m_bound[i] != 0 && m_credit[i] != 0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bound[i] = 0; m_leaf[i] = 0; m_port[i] = 0; m_addr[i] = 0; m_credit[i] = 128;
    end
    m_rr = 0;
    m_dout = '0;
  endtask

  task automatic model_update(input int g, input bit can);
    int op, idx;
    logic [31:0] w;
    if (!reset) begin
      model_reset();
      return;
    end
    if (can) begin
      if (g >= 0) begin
        w = u_if.din_leaf_user2interface[g*32 +: 32];
        m_dout = {1'b1, 5'(m_leaf[g]), 4'(m_port[g]), 7'(m_addr[g]), w};
        m_addr[g] = (m_addr[g] + 1) % 128;
        m_credit[g] = m_credit[g] - 1;
        m_rr = (g + 1) % N;
      end else begin
        m_dout = '0;
      end
    end
    if (din_bft[48] && din_bft[42:39] == 4'd0) begin
      op  = int'(din_bft[31:28]);
      idx = int'(din_bft[27:24]);
      if (idx < N) begin
        if (op == 0) begin
          m_bound[idx] = 1;
          m_leaf[idx]  = int'(din_bft[14:10]);
          m_port[idx]  = int'(din_bft[9:6]);
          m_addr[idx]  = 0;
        end else if (op == 1) begin
          m_credit[idx] = m_credit[idx] + 64;
          if (m_credit[idx] > 128) m_credit[idx] = 128;
        end
      end
    end
  endtask

  // Inputs are set just after a rising edge; ack is checked before the next edge, dout just after it.
  task automatic cycle();
    int g;
    bit can;
    logic [N-1:0] exp_ack;
    #1;
    can = reset && (!resend || !m_dout[48]);
    g = can ? pick() : -1;
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    check("ack", 64'(u_if.ack_interface2user), 64'(exp_ack));
    prev_ack = last_ack;
    last_ack = u_if.ack_interface2user;
    if (g >= 0) ack_count[g]++;
    @(posedge clk_bft);
    model_update(g, can);
    #1;
    check("dout", 64'(dout), 64'(m_dout));
  endtask

  function automatic logic [48:0] ctrl_pkt(input int op, input int idx, input int leaf, input int port);
    return {1'b1, 5'd0, 4'd0, 7'd0, 4'(op), 4'(idx), 9'd0, 5'(leaf), 4'(port), 6'd0};
  endfunction

  task automatic ctrl(input int op, input int idx, input int leaf, input int port);
    din_bft = ctrl_pkt(op, idx, leaf, port);
    cycle();
    din_bft = '0;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    int base;
    logic [48:0] held;
    reset = 1'b0; resend = 1'b0; din_bft = '0;
    u_if.vld_user2interface = '0;
    u_if.din_leaf_user2interface = '0;
    last_ack = '0; prev_ack = '0;
    for (int i = 0; i < N; i++) ack_count[i] = 0;
    model_reset();
    @(posedge clk_bft); #1;
    run(2);
    reset = 1'b1;
    check("reset_dout", 64'(dout), 64'h0);

    // Unbound port never acknowledged
    u_if.vld_user2interface = 2'b01;
    base = ack_count[0];
    run(10);
    check("unbound_acks", 64'(ack_count[0] - base), 64'd0);
    check("unbound_valid", 64'(dout[48]), 64'd0);

    // Bind port0 to leaf 3 / port 2 and send one word
    u_if.vld_user2interface = '0;
    ctrl(0, 0, 3, 2);
    u_if.din_leaf_user2interface[31:0] = 32'hDEADBEEF;
    u_if.vld_user2interface = 2'b01;
    cycle();
    check("bind_ack", 64'(last_ack), 64'h1);
    check("bind_pkt", 64'(dout), 64'h1_1900_DEADBEEF);
    u_if.vld_user2interface = '0;
    cycle();
    check("idle_clear", 64'(dout), 64'h0);

    // Credit exhaustion on port1 and refill
    ctrl(0, 1, 7, 5);
    u_if.vld_user2interface = 2'b10;
    base = ack_count[1];
    for (int c = 0; c < 130; c++) begin
      u_if.din_leaf_user2interface[63:32] = $urandom;
      cycle();
    end
    check("credit_128", 64'(ack_count[1] - base), 64'd128);
    ctrl(1, 1, 0, 0);
    base = ack_count[1];
    for (int c = 0; c < 70; c++) begin
      u_if.din_leaf_user2interface[63:32] = $urandom;
      cycle();
    end
    check("credit_64", 64'(ack_count[1] - base), 64'd64);

    // Resend stall holds the packet
    u_if.vld_user2interface = 2'b01;
    u_if.din_leaf_user2interface[31:0] = 32'h0000_1111;
    cycle();
    held = dout;
    resend = 1'b1;
    for (int c = 0; c < 3; c++) begin
      u_if.din_leaf_user2interface[31:0] = $urandom;
      cycle();
      check("resend_hold", 64'(dout), 64'(held));
      check("resend_noack", 64'(last_ack), 64'h0);
    end
    resend = 1'b0;
    cycle();
    check("resend_addr", 64'(dout[38:32]), 64'((held[38:32] + 7'd1)));

    // Both ports requesting
    ctrl(1, 1, 0, 0);
    ctrl(1, 1, 0, 0);
    u_if.vld_user2interface = 2'b11;
    cycle();
    for (int c = 0; c < 4; c++) begin
      cycle();
`ifdef LEAF_TX_RR_EN
      check("rr_alternate", 64'(last_ack ^ prev_ack), 64'h3);
`else
      check("fixed_port0", 64'(last_ack), 64'h1);
`endif
    end

    // Reset mid-stream clears bindings
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("midreset_dout", 64'(dout), 64'h0);
    base = ack_count[0] + ack_count[1];
    run(5);
    check("midreset_noack", 64'(ack_count[0] + ack_count[1] - base), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      u_if.vld_user2interface = N'($urandom);
      u_if.din_leaf_user2interface = {$urandom, $urandom};
      resend = ($urandom_range(3) == 0);
      reset = ($urandom_range(299) != 0);
      r = $urandom_range(15);
      if (r < 2)       din_bft = ctrl_pkt(0, $urandom_range(2), $urandom_range(31), $urandom_range(15));
      else if (r < 4)  din_bft = ctrl_pkt(1, $urandom_range(2), 0, 0);
      else if (r == 4) din_bft = ctrl_pkt($urandom_range(15), $urandom_range(3), $urandom_range(31), $urandom_range(15));
      else if (r == 5) din_bft = {1'b1, 5'($urandom), 4'($urandom_range(15, 1)), 7'($urandom), 4'd0, 4'd0, 24'($urandom)};
      else             din_bft = '0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
